// File: rtl/sha256_sched_ctrl_pkg.sv
// Shared types and constants for the SHA-256 message-schedule sequencer.
package sha256_sched_ctrl_pkg;

    localparam int unsigned SHA256_WORDS  = 16;
    localparam int unsigned SHA256_ROUNDS = 64;

    localparam logic [3:0] LAST_WORD  = 4'(SHA256_WORDS - 1);
    localparam logic [5:0] LAST_ROUND = 6'(SHA256_ROUNDS - 1);

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        LOAD,
        RUN,
        DONE
    } state_t;

endpackage

// File: rtl/sha256_sched_ctrl_if.sv
// Message-in and W[t]-out valid/ready streams of the schedule sequencer.
interface sha256_sched_ctrl_if;

    logic        msg_valid;
    logic        msg_ready;
    logic [31:0] msg_data;

    logic        wt_valid;
    logic        wt_ready;
    logic [31:0] wt_data;
    logic [5:0]  wt_round;

    // master is the controller: it consumes message words and produces W[t]
    modport master (
        input  msg_valid, msg_data, wt_ready,
        output msg_ready, wt_valid, wt_data, wt_round
    );

    modport slave (
        output msg_valid, msg_data, wt_ready,
        input  msg_ready, wt_valid, wt_data, wt_round
    );

endinterface

// File: rtl/sha256_slot_timer.sv
// Round-slot cycle counter: STN at the first slot cycle, slot_end at the last.
module sha256_slot_timer #(
    parameter int unsigned ROUND_CYCLES = 5
) (
    input  logic clk,
    input  logic reset_n,
    input  logic enable,
    input  logic restart,
    input  logic freeze,
    output logic stn_pulse,
    output logic slot_end
);

    localparam int unsigned K_W = $clog2(ROUND_CYCLES);
    localparam logic [K_W-1:0] K_LAST = K_W'(ROUND_CYCLES - 1);

    logic [K_W-1:0] k;

    // k parks at K_LAST until the round's W[t] is handed off and restart arrives
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            k <= '0;
        end else if (restart) begin
            k <= '0;
        end else if (enable && !freeze && (k != K_LAST)) begin
            k <= k + 1'b1;
        end
    end

    assign stn_pulse = enable && (k == '0);
    assign slot_end  = enable && !freeze && (k == K_LAST);

endmodule

// File: rtl/sha256_sched_ctrl.sv
// SHA-256 message-scheduler sequencer: clear, load M[0..15], step rounds 0..63, stream W[t].
// Optional busy-cycle counter enabled by defining SHA256_CTRL_PERF_EN.
module sha256_sched_ctrl
    import sha256_sched_ctrl_pkg::*;
#(
    parameter int unsigned ROUND_CYCLES = 5
) (
    input  logic                       clk,
    input  logic                       reset_n,
    sha256_sched_ctrl_if.master        bus,
    input  logic                       start,
    output logic [31:0]                sched_word,
    output logic [3:0]                 sched_addr,
    output logic                       sched_we,
    output logic                       sched_stn,
    output logic [5:0]                 sched_round_t,
    output logic                       sched_reset_new_block,
    input  logic [31:0]                sched_wt,
    output logic                       busy,
    output logic                       done,
    output logic [31:0]                perf_cycles
);

    if (ROUND_CYCLES < 5) begin : g_bad_round_cycles
        $error("sha256_sched_ctrl: ROUND_CYCLES must be >= 5");
    end

    state_t      state_q, state_d;
    logic [3:0]  word_idx;
    logic [5:0]  round;
    logic        wt_valid_q;
    logic [31:0] wt_data_q;
    logic [5:0]  wt_round_q;

    logic msg_accept, last_accept, wt_fire;
    logic stn_pulse, slot_end;

    assign msg_accept  = (state_q == LOAD) && bus.msg_valid;
    assign last_accept = msg_accept && (word_idx == LAST_WORD);
    assign wt_fire     = wt_valid_q && bus.wt_ready;

    sha256_slot_timer #(
        .ROUND_CYCLES (ROUND_CYCLES)
    ) u_slot_timer (
        .clk       (clk),
        .reset_n   (reset_n),
        .enable    (state_q == RUN),
        .restart   (last_accept || wt_fire),
        .freeze    (wt_valid_q),
        .stn_pulse (stn_pulse),
        .slot_end  (slot_end)
    );

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: state_d is defaulted before the case so no path leaves it unassigned (no latch).
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = CLEAR;
            CLEAR:   state_d = LOAD;
            LOAD:    if (last_accept) state_d = RUN;
            RUN:     if (wt_fire && (round == LAST_ROUND)) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            word_idx   <= '0;
            round      <= '0;
            wt_valid_q <= 1'b0;
            wt_data_q  <= '0;
            wt_round_q <= '0;
        end else begin
            if (state_q == CLEAR) begin
                word_idx <= '0;
            end else if (msg_accept && (word_idx != LAST_WORD)) begin
                word_idx <= word_idx + 1'b1;
            end

            if ((state_q == CLEAR) || last_accept) begin
                round <= '0;
            end else if (wt_fire && (round != LAST_ROUND)) begin
                round <= round + 1'b1;
            end

            // W[t] is sampled once per slot; it stays put until compression takes it
            if (slot_end) begin
                wt_data_q  <= sched_wt;
                wt_round_q <= round;
                wt_valid_q <= 1'b1;
            end else if (wt_fire) begin
                wt_valid_q <= 1'b0;
            end
        end
    end

    always_comb begin
        busy                  = 1'b0;
        done                  = 1'b0;
        bus.msg_ready         = 1'b0;
        sched_we              = 1'b0;
        sched_addr            = '0;
        sched_word            = '0;
        sched_stn             = 1'b0;
        sched_round_t         = '0;
        sched_reset_new_block = 1'b1;
        case (state_q)
            CLEAR: begin
                busy                  = 1'b1;
                sched_reset_new_block = 1'b0;
            end
            LOAD: begin
                busy          = 1'b1;
                bus.msg_ready = 1'b1;
                sched_we      = bus.msg_valid;
                sched_addr    = bus.msg_valid ? word_idx : '0;
                sched_word    = bus.msg_valid ? bus.msg_data : '0;
            end
            RUN: begin
                busy          = 1'b1;
                sched_stn     = stn_pulse;
                sched_round_t = round;
            end
            DONE: begin
                busy          = 1'b1;
                done          = 1'b1;
                sched_round_t = round;
            end
            default: ;
        endcase
    end

    assign bus.wt_valid = wt_valid_q;
    assign bus.wt_data  = wt_data_q;
    assign bus.wt_round = wt_round_q;

`ifdef SHA256_CTRL_PERF_EN
    logic [31:0] perf_q;

    // The CLEAR cycle reloads zero, so a block reports its LOAD..DONE cycle count
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            perf_q <= '0;
        end else if (state_q == CLEAR) begin
            perf_q <= '0;
        end else if ((state_q != IDLE) && (perf_q != '1)) begin
            perf_q <= perf_q + 1'b1;
        end
    end

    assign perf_cycles = perf_q;
`else
    assign perf_cycles = '0;
`endif

endmodule
